// File: rtl/code_packer.sv
// Packs a stream of CodeWidth-bit codes LSB-first into bytes, with a small code FIFO and a flush sequence.
// Optional CODE_PACKER_STATS_EN adds a CodeCount output that counts accepted codes.
module code_packer #(
    parameter int CodeWidth = 9,
    parameter int FifoDepth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CodeWidth-1:0] CodeInput,
    input  logic                 CodeInputReady,
    input  logic                 Flush,
    output logic [7:0]           ByteOutput,
    output logic                 ByteOutputValid,
    input  logic                 ByteOutputAccept,
    output logic                 FlushDone,
    output logic                 Busy,
    output logic                 Overflow
`ifdef CODE_PACKER_STATS_EN
    ,
    output logic [15:0]          CodeCount
`endif
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;
    localparam int AccW = CodeWidth + 7;
    localparam int BitW = $clog2(AccW + 1);

    typedef enum logic [1:0] {
        ST_PACK,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    logic [CodeWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      fifo_count;
    logic [AccW-1:0]      acc;
    logic [BitW-1:0]      bit_count;
    state_t               state;
    state_t               next_state;
    logic                 push;
    logic                 pop;
    logic                 out_free;
    logic                 emit;
    logic                 pad_emit;
    logic                 done_set;

    // Fullness uses the registered count, so a same-cycle pop never rescues a push.
    assign push     = CodeInputReady && (fifo_count < CntW'(FifoDepth));
    assign pop      = (bit_count < BitW'(8)) && (fifo_count != '0);
    assign out_free = !ByteOutputValid || ByteOutputAccept;
    assign emit     = (bit_count >= BitW'(8)) && out_free;
    assign Busy     = (fifo_count != '0) || (bit_count != '0) || ByteOutputValid || (state != ST_PACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PACK;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        pad_emit   = 1'b0;
        done_set   = 1'b0;
        case (state)
            ST_PACK: begin
                if (Flush) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if ((fifo_count == '0) && (bit_count < BitW'(8)) && out_free) begin
                    pad_emit   = (bit_count != '0);
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!ByteOutputValid) begin
                    done_set   = 1'b1;
                    next_state = ST_PACK;
                end
            end
            default: next_state = ST_PACK;
        endcase
    end

    // NOTE: FIFO storage is not reset; pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= CodeInput;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Bits above bit_count are always zero, so a pad byte is naturally zero-filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            bit_count <= '0;
        end else if (pop) begin
            acc       <= acc | (AccW'(mem[rd_ptr]) << bit_count);
            bit_count <= bit_count + BitW'(CodeWidth);
        end else if (emit) begin
            acc       <= acc >> 8;
            bit_count <= bit_count - BitW'(8);
        end else if (pad_emit) begin
            acc       <= '0;
            bit_count <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ByteOutput      <= '0;
            ByteOutputValid <= 1'b0;
            FlushDone       <= 1'b0;
            Overflow        <= 1'b0;
        end else begin
            if (emit || pad_emit) begin
                ByteOutput      <= acc[7:0];
                ByteOutputValid <= 1'b1;
            end else if (ByteOutputAccept) begin
                ByteOutputValid <= 1'b0;
            end
            FlushDone <= done_set;
            if (CodeInputReady && !push) Overflow <= 1'b1;
        end
    end

`ifdef CODE_PACKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CodeCount <= '0;
        end else if (push) begin
            CodeCount <= CodeCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_code_packer.sv
// Directed self-checking bench for code_packer; inputs change 1ns after the rising edge, outputs are sampled there or on the falling edge.
module tb_code_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] CodeInput;
    logic       CodeInputReady;
    logic       Flush;
    logic [7:0] ByteOutput;
    logic       ByteOutputValid;
    logic       ByteOutputAccept;
    logic       FlushDone;
    logic       Busy;
    logic       Overflow;
`ifdef CODE_PACKER_STATS_EN
    logic [15:0] CodeCount;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] bytes [$];
    int fd_count = 0;

    code_packer #(.CodeWidth(9), .FifoDepth(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .CodeInput        (CodeInput),
        .CodeInputReady   (CodeInputReady),
        .Flush            (Flush),
        .ByteOutput       (ByteOutput),
        .ByteOutputValid  (ByteOutputValid),
        .ByteOutputAccept (ByteOutputAccept),
        .FlushDone        (FlushDone),
        .Busy             (Busy),
        .Overflow         (Overflow)
`ifdef CODE_PACKER_STATS_EN
        ,
        .CodeCount        (CodeCount)
`endif
    );

    always #5 clk = ~clk;

    // A byte seen valid and accepted here is consumed at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ByteOutputValid && ByteOutputAccept) bytes.push_back(ByteOutput);
            if (FlushDone) fd_count++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [8:0] code);
        CodeInput      = code;
        CodeInputReady = 1'b1;
        @(posedge clk);
        #1;
        CodeInputReady = 1'b0;
    endtask

    task automatic flush_req();
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        CodeInput        = '0;
        CodeInputReady   = 1'b0;
        Flush            = 1'b0;
        ByteOutputAccept = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic wait_done(input int fdb, input int budget, input string name);
        int n = 0;
        while (fd_count == fdb && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (fd_count == fdb) begin
            errors++;
            $display("FAIL %s_flushdone: no FlushDone pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        CodeInput        = '0;
        CodeInputReady   = 1'b0;
        Flush            = 1'b0;
        ByteOutputAccept = 1'b0;
        #1;
        checks++; if (ByteOutput !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", ByteOutput); end
        checks++; if (ByteOutputValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ByteOutputValid); end
        checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL reset_flushdone: got %b want 0", FlushDone); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
`ifdef CODE_PACKER_STATS_EN
        checks++; if (CodeCount !== 16'd0) begin errors++; $display("FAIL reset_codecount: got %0d want 0", CodeCount); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_pad_flush();
        logic [7:0] exp [3];
        int base;
        int fdb;
        exp = '{8'hFF, 8'h01, 8'h00};
        do_reset();
        ByteOutputAccept = 1'b1;
        base = bytes.size();
        fdb  = fd_count;
        push(9'h1FF);
        push(9'h000);
        flush_req();
        wait_done(fdb, 60, "pad");
        checks++;
        if (bytes.size() - base != 3) begin errors++; $display("FAIL pad_count: got %0d bytes want 3", bytes.size() - base); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bytes.size() <= base + i) begin
                errors++; $display("FAIL pad_byte%0d: missing want %h", i, exp[i]);
            end else if (bytes[base+i] !== exp[i]) begin
                errors++; $display("FAIL pad_byte%0d: got %h want %h", i, bytes[base+i], exp[i]);
            end
        end
        checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL pad_pulse_width: FlushDone got %b want 0", FlushDone); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL pad_busy: got %b want 0", Busy); end
    endtask

    task automatic test_aligned_flush();
        logic [7:0] exp [9];
        int base;
        int fdb;
        exp = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        do_reset();
        ByteOutputAccept = 1'b1;
        base = bytes.size();
        fdb  = fd_count;
        for (int i = 0; i < 8; i++) begin
            push(9'h100);
            idle(1);
        end
        flush_req();
        wait_done(fdb, 80, "aligned");
        idle(3);
        checks++;
        if (bytes.size() - base != 9) begin errors++; $display("FAIL aligned_count: got %0d bytes want 9", bytes.size() - base); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bytes.size() <= base + i) begin
                errors++; $display("FAIL aligned_byte%0d: missing want %h", i, exp[i]);
            end else if (bytes[base+i] !== exp[i]) begin
                errors++; $display("FAIL aligned_byte%0d: got %h want %h", i, bytes[base+i], exp[i]);
            end
        end
        checks++; if (fd_count - fdb != 1) begin errors++; $display("FAIL aligned_pulses: got %0d FlushDone pulses want 1", fd_count - fdb); end
    endtask

    task automatic test_stall_overflow();
        logic [7:0] exp [7];
        int base;
        int fdb;
        exp = '{8'h01, 8'h04, 8'h0C, 8'h20, 8'h50, 8'hC0, 8'h00};
        do_reset();
        base = bytes.size();
        for (int i = 1; i <= 7; i++) begin
            CodeInput      = 9'(i);
            CodeInputReady = 1'b1;
            @(posedge clk);
            #1;
            if (i == 6) begin
                checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL stall_no_overflow_yet: got %b want 0", Overflow); end
            end
        end
        CodeInputReady = 1'b0;
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow: got %b want 1", Overflow); end
        checks++; if (ByteOutputValid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", ByteOutputValid); end
        checks++; if (ByteOutput !== 8'h01) begin errors++; $display("FAIL stall_byte: got %h want 01", ByteOutput); end
        idle(3);
        checks++; if (ByteOutput !== 8'h01) begin errors++; $display("FAIL stall_byte_stable: got %h want 01", ByteOutput); end
        checks++; if (bytes.size() != base) begin errors++; $display("FAIL stall_no_transfer: got %0d bytes want 0", bytes.size() - base); end
`ifdef CODE_PACKER_STATS_EN
        checks++; if (CodeCount !== 16'd6) begin errors++; $display("FAIL stall_codecount: got %0d want 6", CodeCount); end
`endif
        fdb = fd_count;
        ByteOutputAccept = 1'b1;
        flush_req();
        wait_done(fdb, 80, "stall");
        checks++;
        if (bytes.size() - base != 7) begin errors++; $display("FAIL stall_count: got %0d bytes want 7", bytes.size() - base); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bytes.size() <= base + i) begin
                errors++; $display("FAIL stall_byte%0d: missing want %h", i, exp[i]);
            end else if (bytes[base+i] !== exp[i]) begin
                errors++; $display("FAIL stall_byte%0d: got %h want %h", i, bytes[base+i], exp[i]);
            end
        end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow_sticky: got %b want 1", Overflow); end
    endtask

    task automatic test_mid_reset();
        int base;
        int fdb;
        do_reset();
        for (int i = 0; i < 5; i++) push(9'(9'h011 + i));
        idle(2);
        checks++; if (ByteOutputValid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", ByteOutputValid); end
        rst = 1'b1;
        #1;
        checks++; if (ByteOutput !== 8'h00) begin errors++; $display("FAIL midrst_byte: got %h want 00", ByteOutput); end
        checks++; if (ByteOutputValid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", ByteOutputValid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", Busy); end
        rst = 1'b0;
        idle(1);
        ByteOutputAccept = 1'b1;
        base = bytes.size();
        fdb  = fd_count;
        push(9'h0AB);
        flush_req();
        wait_done(fdb, 60, "midrst");
        checks++;
        if (bytes.size() - base != 2) begin
            errors++; $display("FAIL midrst_count: got %0d bytes want 2", bytes.size() - base);
        end else begin
            if (bytes[base] !== 8'hAB) begin errors++; $display("FAIL midrst_byte0: got %h want ab", bytes[base]); end
            checks++;
            if (bytes[base+1] !== 8'h00) begin errors++; $display("FAIL midrst_byte1: got %h want 00", bytes[base+1]); end
        end
    endtask

    task automatic test_empty_flush();
        int base;
        do_reset();
        ByteOutputAccept = 1'b1;
        base = bytes.size();
        flush_req();
        @(negedge clk);
        checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL empty_fd_c0: got %b want 0", FlushDone); end
        @(negedge clk);
        checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL empty_fd_c1: got %b want 0", FlushDone); end
        @(negedge clk);
        checks++; if (FlushDone !== 1'b1) begin errors++; $display("FAIL empty_fd_c2: got %b want 1", FlushDone); end
        @(negedge clk);
        checks++; if (FlushDone !== 1'b0) begin errors++; $display("FAIL empty_fd_c3: got %b want 0", FlushDone); end
        checks++; if (bytes.size() != base) begin errors++; $display("FAIL empty_no_byte: got %0d bytes want 0", bytes.size() - base); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b want 0", Busy); end
    endtask

    initial begin
        test_reset();
        test_pad_flush();
        test_aligned_flush();
        test_stall_overflow();
        test_mid_reset();
        test_empty_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
